// File: rtl/posit_field_mul_if.sv
// Shared sign type and the operand/result handshake bundle for posit_field_mul.
// The master side supplies operands and accepts results; the slave side is the multiplier.
package posit_field_mul_pkg;
  typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;
endpackage

interface posit_field_mul_if;
  import posit_field_mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  sign_t             a_sign;
  sign_t             b_sign;
  logic signed [7:0] a_regime;
  logic signed [7:0] b_regime;
  logic signed [7:0] a_exponent;
  logic signed [7:0] b_exponent;
  logic        [7:0] a_mantissa;
  logic        [7:0] b_mantissa;
  logic              a_zero;
  logic              b_zero;

  logic              out_valid;
  logic              out_ready;
  sign_t             sign;
  logic signed [7:0] regime;
  logic signed [7:0] exponent;
  logic        [7:0] mantissa;
  logic              zero;
  logic              sat;

  modport master (
    output in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
           a_mantissa, b_mantissa, a_zero, b_zero, out_ready,
    input  in_ready, out_valid, sign, regime, exponent, mantissa, zero, sat
  );

  modport slave (
    input  in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
           a_mantissa, b_mantissa, a_zero, b_zero, out_ready,
    output in_ready, out_valid, sign, regime, exponent, mantissa, zero, sat
  );
endinterface

// File: rtl/posit_field_mul.sv
// Two-stage multiplier for decoded posit fields: S1 forms the combined scale and the
// significand product, S2 normalises, splits into regime/exponent and saturates.
module posit_field_mul
  import posit_field_mul_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int EN    = 1
) (
  input logic clk,
  input logic rst_n,
  posit_field_mul_if.slave bus
);

  localparam logic signed [10:0] LIM = 11'(WIDTH - 2);

  logic              adv;
  logic              s1_valid;
  logic              s2_valid;
  logic signed [9:0] s1_sum;
  sign_t             s1_sign;
  logic              s1_zero;
  logic        [9:0] s1_prod;

  logic signed [9:0] scale_a;
  logic signed [9:0] scale_b;
  logic       [17:0] prod;
  logic              unused_prod_lo;

  logic signed [10:0] sum_n;
  logic signed [10:0] reg_full;
  logic        [7:0]  exp_low;
  logic        [7:0]  frac;

  assign adv          = ~s2_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = s2_valid;

  // scale = regime * 2^EN + exponent, kept in 10 signed bits
  assign scale_a = ($signed({{2{bus.a_regime[7]}}, bus.a_regime}) <<< EN)
                 + $signed({{2{bus.a_exponent[7]}}, bus.a_exponent});
  assign scale_b = ($signed({{2{bus.b_regime[7]}}, bus.b_regime}) <<< EN)
                 + $signed({{2{bus.b_exponent[7]}}, bus.b_exponent});

  assign prod           = 18'({1'b1, bus.a_mantissa}) * 18'({1'b1, bus.b_mantissa});
  assign unused_prod_lo = ^prod[7:0];

  // Only P[17:8] survives truncation, so S1 keeps just that slice of the product
  assign sum_n    = $signed({s1_sum[9], s1_sum}) + $signed({10'd0, s1_prod[9]});
  assign frac     = s1_prod[9] ? s1_prod[8:1] : s1_prod[7:0];
  assign reg_full = sum_n >>> EN;
  assign exp_low  = 8'(sum_n - (reg_full <<< EN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_sign      <= POS;
      s1_zero      <= 1'b0;
      s1_prod      <= '0;
      bus.sign     <= POS;
      bus.regime   <= '0;
      bus.exponent <= '0;
      bus.mantissa <= '0;
      bus.zero     <= 1'b0;
      bus.sat      <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      if (bus.in_valid) begin
        s1_sum  <= scale_a + scale_b;
        s1_sign <= sign_t'(bus.a_sign ^ bus.b_sign);
        s1_zero <= bus.a_zero | bus.b_zero;
        s1_prod <= prod[17:8];
      end
      if (s1_valid) begin
        bus.zero <= s1_zero;
        if (s1_zero) begin
          bus.sign     <= POS;
          bus.regime   <= '0;
          bus.exponent <= '0;
          bus.mantissa <= '0;
          bus.sat      <= 1'b0;
        end else if (reg_full > LIM) begin
          bus.sign     <= s1_sign;
          bus.regime   <= LIM[7:0];
          bus.exponent <= '0;
          bus.mantissa <= '0;
          bus.sat      <= 1'b1;
        end else if (reg_full < -LIM) begin
          bus.sign     <= s1_sign;
          bus.regime   <= 8'(-LIM);
          bus.exponent <= '0;
          bus.mantissa <= '0;
          bus.sat      <= 1'b1;
        end else begin
          bus.sign     <= s1_sign;
          bus.regime   <= reg_full[7:0];
          bus.exponent <= exp_low;
          bus.mantissa <= frac;
          bus.sat      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_field_mul.sv
// Directed bench for posit_field_mul (WIDTH=7, EN=1): hand-computed products, saturation,
// zero handling, a stalled stream and reset with data in flight.
module tb_posit_field_mul;
  import posit_field_mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  posit_field_mul_if bus ();

  posit_field_mul #(.WIDTH(7), .EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(sign_t s, logic [7:0] r, logic [7:0] e,
                                       logic [7:0] m, logic z, logic st);
    return {5'd0, s, r, e, m, z, st};
  endfunction

  function automatic logic [31:0] observed();
    return pack(bus.sign, bus.regime, bus.exponent, bus.mantissa, bus.zero, bus.sat);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic setOperands(sign_t as, logic signed [7:0] ar, logic signed [7:0] ae,
                             logic [7:0] am, logic az, sign_t bs, logic signed [7:0] br,
                             logic signed [7:0] be, logic [7:0] bm, logic bz);
    bus.a_sign = as; bus.a_regime = ar; bus.a_exponent = ae; bus.a_mantissa = am; bus.a_zero = az;
    bus.b_sign = bs; bus.b_regime = br; bus.b_exponent = be; bus.b_mantissa = bm; bus.b_zero = bz;
  endtask

  // One isolated operation: accepted on the first edge, visible after the second
  task automatic applyStimulus(string tag, logic [31:0] exp);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput(tag, observed(), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic signed [7:0] stream_reg [4] = '{8'sd0, 8'sd1, 8'sd2, -8'sd1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    setOperands(POS, 0, 0, 0, 0, POS, 0, 0, 0, 0);
    #3;
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_fields", observed(), pack(POS, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);

    // 3 * 3 = 9
    setOperands(POS, 0, 1, 8'h80, 0, POS, 0, 1, 8'h80, 0);
    applyStimulus("three_sq", pack(POS, 8'sd1, 8'sd1, 8'h20, 0, 0));
    setOperands(NEG, -8'sd2, 0, 8'h00, 0, POS, 0, 1, 8'h00, 0);
    applyStimulus("neg_small", pack(NEG, -8'sd2, 8'sd1, 8'h00, 0, 0));
    // 1.75 * 1.25 = 2.1875
    setOperands(POS, 0, 0, 8'hC0, 0, POS, 0, 0, 8'h40, 0);
    applyStimulus("frac_mul", pack(POS, 8'sd0, 8'sd1, 8'h18, 0, 0));
    setOperands(POS, 8'sd3, 0, 8'h00, 0, POS, 8'sd3, 0, 8'h00, 0);
    applyStimulus("sat_high", pack(POS, 8'sd5, 0, 0, 0, 1));
    setOperands(NEG, -8'sd3, 0, 8'h00, 0, NEG, -8'sd3, 0, 8'h00, 0);
    applyStimulus("sat_low", pack(POS, -8'sd5, 0, 0, 0, 1));
    setOperands(POS, 8'sd2, 1, 8'h00, 0, NEG, 8'sd3, 0, 8'h00, 0);
    applyStimulus("edge_high", pack(NEG, 8'sd5, 8'sd1, 8'h00, 0, 0));
    setOperands(POS, -8'sd3, 0, 8'h00, 0, POS, -8'sd2, 0, 8'h00, 0);
    applyStimulus("edge_low", pack(POS, -8'sd5, 8'sd0, 8'h00, 0, 0));
    setOperands(POS, 8'sd2, 1, 8'hAA, 1, NEG, 8'sd1, 1, 8'h55, 0);
    applyStimulus("zero_op", pack(POS, 0, 0, 0, 1, 0));

    // Four back-to-back inputs with a three-cycle downstream stall after the first result
    @(posedge clk); #1;
    fork
      begin
        bit accepted;
        for (int k = 0; k < 4; k++) begin
          setOperands(POS, stream_reg[k], 0, 8'h00, 0, POS, 0, 0, 8'h00, 0);
          bus.in_valid = 1'b1;
          accepted = 1'b0;
          for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk); #1;
          end
          if (!accepted) checkOutput("stream_accept", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        int idx;
        bit prev_stall;
        logic [31:0] held;
        idx = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            if (idx < 4)
              checkOutput($sformatf("stream_%0d", idx), observed(),
                          pack(POS, stream_reg[idx], 0, 0, 0, 0));
            idx++;
          end
          if (bus.out_valid && !bus.out_ready) begin
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (prev_stall) checkOutput("stall_hold", observed(), held);
            held = observed();
            prev_stall = 1'b1;
          end else begin
            prev_stall = 1'b0;
          end
        end
        checkOutput("stream_count", 32'(idx), 32'd4);
      end
    join

    // Two results in flight when reset hits
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    setOperands(POS, 8'sd1, 1, 8'h40, 0, NEG, 8'sd1, 0, 8'h40, 0);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checkOutput("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_fields", observed(), pack(POS, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    setOperands(POS, 0, 1, 8'h80, 0, POS, 0, 1, 8'h80, 0);
    applyStimulus("post_reset", pack(POS, 8'sd1, 8'sd1, 8'h20, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/posit_field_mul.md
POSIT_FIELD_MUL -- requirements
Module: posit_field_mul

Interface
REQ-001 Parameter WIDTH, default 7, meaning posit bit width of the operands the fields were decoded from; legal range 4..8.
REQ-002 Parameter EN, default 1, meaning exponent field width in bits; legal range 0..3.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 a_sign, b_sign  input  sign_t  operand signs (POS/NEG).
REQ-009 a_regime, b_regime  input  8 signed  decoded regime values.
REQ-010 a_exponent, b_exponent  input  8 signed  decoded exponents, range 0..2^EN-1.
REQ-011 a_mantissa, b_mantissa  input  8 unsigned  fraction bits, left-aligned (MSB weight 1/2), hidden 1 implicit.
REQ-012 a_zero, b_zero  input  1  operand is zero; its other fields are ignored.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 sign  output  sign_t.  regime  output  8 signed.  exponent  output  8 signed.  mantissa  output  8 unsigned.  zero  output  1.  sat  output  1 (result clamped).

Function
REQ-016 Two-stage pipeline (S1, S2) with a single advance enable adv = ~out_valid | out_ready; in_ready SHALL equal adv.
REQ-017 Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready; latency from accepted input to out_valid SHALL be exactly 2 cycles with no stall.
REQ-018 When adv=0, S1 and S2 contents and all outputs SHALL hold unchanged; in_valid is not consumed.
REQ-019 When adv=1, S1 valid loads in_valid & in_ready and S2 valid loads S1 valid; bubbles propagate; sustained throughput one result per cycle.
REQ-020 S1: scale_x = regime_x * 2^EN + exponent_x (10-bit signed); sum = scale_a + scale_b; sign = a_sign XOR b_sign; zero = a_zero | b_zero; product P = {1,a_mantissa} * {1,b_mantissa} (18-bit unsigned), all registered.
REQ-021 S2 normalise: if P[17]=1, sum increments by 1 and fraction = P[16:9]; else fraction = P[15:8]; discarded bits truncated (round toward zero).
REQ-022 S2 split: regime = sum >>> EN (arithmetic), exponent = sum[EN-1:0] zero-extended (0 when EN=0), mantissa = fraction.
REQ-023 Saturation: if regime > WIDTH-2, output regime=WIDTH-2, exponent=0, mantissa=0, sat=1; if regime < -(WIDTH-2), output regime=-(WIDTH-2), exponent=0, mantissa=0, sat=1; otherwise sat=0.
REQ-024 When zero=1: sign=POS, regime=0, exponent=0, mantissa=0, sat=0, regardless of other fields.
REQ-025 Output fields are registered in S2 and SHALL only change on a cycle with adv=1 and S1 valid=1; out_valid falls after a handshake with no S1 data behind it.
REQ-026 Simultaneous in and out handshakes in the same cycle SHALL both complete with no loss or duplication.

Reset
REQ-027 rst_n low SHALL asynchronously clear S1 and S2 valid, out_valid=0, sign=POS, regime=0, exponent=0, mantissa=0, zero=0, sat=0.
REQ-028 Reset mid-operation SHALL discard all in-flight data; first out_valid after release only follows an input accepted after release.
REQ-029 in_ready SHALL be 1 while in reset and in the first cycle after release (out_valid=0).

Verification
REQ-030 WIDTH=7, EN=1: a=b=(POS, regime 0, exp 1, mant 0x80) [value 3] -> two cycles later sign=POS, regime=1, exponent=1, mantissa=0x20, sat=0 [value 9].
REQ-031 a=(NEG, regime -2, exp 0, mant 0x00), b=(POS, regime 0, exp 1, mant 0x00) -> sign=NEG, regime=-2, exponent=1, mantissa=0x00.
REQ-032 a=b=(POS, regime 3, exp 0, mant 0x00) -> regime=5, exponent=0, mantissa=0, sat=1; mirrored regime -3 each -> regime=-5, sat=1.
REQ-033 a_zero=1, b arbitrary NEG -> zero=1, sign=POS, all fields 0.
REQ-034 Stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs held stable, all 4 results delivered in order, none duplicated.
REQ-035 Assert rst_n low with 2 results in flight -> out_valid=0 immediately, no stale result after release.
